program_loader_stream: RTL and testbench

PROGRAM_LOADER_STREAM -- requirements
Module: program_loader_stream

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/program_loader_stream.sv | 124 ++++++++++++
 tb/tb_program_loader_stream.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared state encoding and default widths for the program loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package program_loader_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/program_loader_stream.sv
// ============================================================================
// Module      : program_loader_stream
// Description : Streams program words into a memory from a base address,
//               keeping a running checksum and a sticky wrap-around flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module program_loader_stream
    import program_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              load_done,
    output logic [DATA_W-1:0] checksum,
    output logic              wrap_err
);

    localparam logic [ADDR_W-1:0] c_LAST_PTR = '1;
    localparam logic [ADDR_W:0]   c_ONE_LEFT = (ADDR_W+1)'(1);

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic [DATA_W-1:0] r_checksum;
    logic              r_wrap_err;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_busy;
    logic              r_load_done;
    logic              w_accept;
    logic              w_start_ok;

    // Abort takes precedence over the handshake, so an aborted beat is dropped.
    assign w_accept   = (r_state == ST_LOAD) && in_valid && !abort;
    assign w_start_ok = (r_state != ST_LOAD) && start;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = (length == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_accept && (r_remaining == c_ONE_LEFT)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_checksum  <= '0;
            r_wrap_err  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_busy      <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt == ST_LOAD);
            r_load_done <= (w_state_nxt == ST_DONE);
            r_mem_write <= w_accept;

            if (w_accept) begin
                r_mem_addr  <= r_ptr;
                r_mem_data  <= in_data;
                r_ptr       <= r_ptr + 1'b1;
                r_checksum  <= r_checksum + in_data;
                r_remaining <= r_remaining - 1'b1;
                if ((r_ptr == c_LAST_PTR) && (r_remaining > c_ONE_LEFT)) begin
                    r_wrap_err <= 1'b1;
                end
            end

            if (w_start_ok) begin
                r_ptr       <= base_addr;
                r_remaining <= length;
                r_checksum  <= '0;
                if (length != '0) begin
                    r_wrap_err <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = (r_state == ST_LOAD);
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;
    assign busy      = r_busy;
    assign load_done = r_load_done;
    assign checksum  = r_checksum;
    assign wrap_err  = r_wrap_err;

endmodule

`default_nettype wire

// File: tb/tb_program_loader_stream.sv
// ============================================================================
// Module      : tb_program_loader_stream
// Description : Directed scenarios plus random traffic against a behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader_stream;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              busy;
    logic              load_done;
    logic [DATA_W-1:0] checksum;
    logic              wrap_err;

    program_loader_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .load_done (load_done),
        .checksum  (checksum),
        .wrap_err  (wrap_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural view: is a load running, has one finished, where are we, what's left.
    bit m_loading, m_done, m_wrap, m_wr;
    int m_ptr, m_left, m_sum, m_addr, m_data;
    int wr_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        m_wr = 1'b0;
        if (reset) begin
            m_loading = 0; m_done = 0; m_wrap = 0;
            m_ptr = 0; m_left = 0; m_sum = 0; m_addr = 0; m_data = 0;
        end else if (m_loading) begin
            if (abort) begin
                m_loading = 0;
            end else if (in_valid) begin
                m_wr   = 1'b1;
                m_addr = m_ptr;
                m_data = int'(in_data);
                if (m_ptr == DEPTH - 1 && m_left > 1) m_wrap = 1;
                m_ptr  = (m_ptr + 1) % DEPTH;
                m_sum  = (m_sum + int'(in_data)) % 65536;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_loading = 0;
                    m_done    = 1;
                end
            end
        end else if (start) begin
            m_sum = 0;
            if (length == 0) begin
                m_done = 1;
            end else begin
                m_done    = 0;
                m_loading = 1;
                m_ptr     = int'(base_addr);
                m_left    = int'(length);
                m_wrap    = 0;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        chk("in_ready",  32'(in_ready),  32'(m_loading));
        chk("busy",      32'(busy),      32'(m_loading));
        chk("load_done", 32'(load_done), 32'(m_done));
        chk("mem_write", 32'(mem_write), 32'(m_wr));
        chk("mem_addr",  32'(mem_addr),  32'(m_addr));
        chk("mem_data",  32'(mem_data),  32'(m_data));
        chk("checksum",  32'(checksum),  32'(m_sum));
        chk("wrap_err",  32'(wrap_err),  32'(m_wrap));
        if (mem_write) wr_log.push_back(int'(mem_addr));
    endtask

    task automatic do_start(input int b, input int len);
        base_addr = ADDR_W'(b);
        length    = (ADDR_W+1)'(len);
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic feed(input logic [DATA_W-1:0] w, input int gaps);
        in_valid = 1'b0;
        for (int g = 0; g < gaps; g++) cyc();
        in_valid = 1'b1;
        in_data  = w;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic chk_log(input string tag, input int exp[$]);
        chk({tag, "_count"}, 32'(wr_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wr_log.size(); i++)
            chk({tag, "_addr"}, 32'(wr_log[i]), 32'(exp[i]));
    endtask

    initial begin
        reset = 1'b1;
        cyc();
        cyc();
        chk("reset_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        cyc();

        // Contiguous load, back-to-back beats.
        wr_log.delete();
        do_start(3, 4);
        feed(16'h1111, 0); feed(16'h2222, 0); feed(16'h3333, 0); feed(16'h4444, 0);
        chk("s1_done", 32'(load_done), 32'd1);
        chk("s1_sum",  32'(checksum),  32'hAAAA);
        chk_log("s1", '{3, 4, 5, 6});
        cyc();

        // Load that crosses the top of memory.
        wr_log.delete();
        do_start(30, 4);
        for (int i = 0; i < 4; i++) feed(DATA_W'(i + 1), 0);
        chk("s2_wrap", 32'(wrap_err), 32'd1);
        chk_log("s2", '{30, 31, 0, 1});

        // Zero-length start.
        wr_log.delete();
        do_start(7, 0);
        chk("s3_done", 32'(load_done), 32'd1);
        chk("s3_sum",  32'(checksum),  32'd0);
        cyc();
        chk_log("s3", '{});

        // Source with idle gaps.
        wr_log.delete();
        do_start(12, 3);
        for (int i = 0; i < 3; i++) feed(DATA_W'(16'h0100 + i), 2);
        cyc(); cyc();
        chk_log("s4", '{12, 13, 14});
        chk("s4_done", 32'(load_done), 32'd1);

        // Abort after two of five words, then a fresh load.
        wr_log.delete();
        do_start(8, 5);
        feed(16'h0005, 0); feed(16'h0006, 0);
        abort = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD; start = 1'b1;
        cyc();
        abort = 1'b0; in_valid = 1'b0; start = 1'b0;
        chk("s5_busy", 32'(busy),      32'd0);
        chk("s5_done", 32'(load_done), 32'd0);
        chk("s5_sum",  32'(checksum),  32'd11);
        cyc();
        chk_log("s5", '{8, 9});
        wr_log.delete();
        do_start(10, 2);
        feed(16'h1000, 0); feed(16'h0234, 0);
        chk("s5b_sum", 32'(checksum), 32'h1234);
        chk_log("s5b", '{10, 11});

        // Reset in the middle of a load.
        do_start(20, 5);
        feed(16'hBEEF, 0);
        reset = 1'b1; start = 1'b1; abort = 1'b1; in_valid = 1'b1;
        cyc();
        reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        chk("s6_outs", {16'(checksum), 5'(mem_addr), 11'(mem_data)}, 32'd0);
        chk("s6_flags", {in_ready, mem_write, busy, load_done, wrap_err}, 5'd0);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 14) == 0);
            abort     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = DATA_W'($urandom);
            base_addr = ADDR_W'($urandom);
            length    = (ADDR_W+1)'($urandom_range(0, DEPTH));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
